ahb_lite_decoder: RTL
=====================

# ahb_lite_decoder

Parametrised single-master AHB-Lite address decoder and response multiplexer that replaces fixed point-to-point MEM/MMIO wiring between the processor and its slave subsystems (memory, IO, future peripherals). It decodes a configurable address field into up to 8 slave selects, registers the data-phase selection, and muxes HREADY/HRESP/HRDATA back to the master. A built-in default slave returns AHB two-cycle ERROR responses for unmapped addresses, and an optional watchdog does the same for hung slaves.

## Interface
- NUM_SLAVES, 4, number of slave ports, legal range 1..8
- DEC_LSB, 28, LSB of the HADDR decode field
- DEC_W, 4, width of the decode field; slave i is selected when HADDR[DEC_LSB+DEC_W-1:DEC_LSB] == i
- TIMEOUT_CYCLES, 255, watchdog limit in cycles, range 2..65535; used only with AHB_DEC_TIMEOUT_EN
- HCLK  in  1  bus clock; the only clock
- HRESETN  in  1  asynchronous active-low reset
- HADDR_M0 / HTRANS_M0 / HWRITE_M0 / HSIZE_M0 / HBURST_M0 / HPROT_M0 / HMASTLOCK_M0 / HWDATA_M0  in  32/2/1/3/3/4/1/32  master request
- HREADY_M0  out  1  muxed ready to master
- HRESP_M0  out  2  muxed response; bit 0 is ERROR, bit 1 is always 0
- HRDATA_M0  out  32  muxed read data
- HSEL_S  out  NUM_SLAVES  one-hot address-phase selects
- HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HMASTLOCK_S, HWDATA_S  out  as master  broadcast copies of the master request
- HREADY_S  out  1  copy of HREADY_M0, driven to all slaves
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready
- HRESP_S  in  NUM_SLAVES  per-slave ERROR bit
- HRDATA_S  in  32*NUM_SLAVES  packed read data; slave i occupies bits [32i+31:32i]
- TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog fires

## Operation
- Address phase is combinational. The decoder computes idx from the decode field. HSEL_S[idx] is 1 when idx < NUM_SLAVES; all other HSEL_S bits are 0. HSEL_S is independent of HTRANS.
- Data-phase register {dvalid, ddef, didx} loads on every HCLK edge where HREADY_M0=1:
  - dvalid = HTRANS_M0[1]
  - ddef = (idx >= NUM_SLAVES)
  - didx = idx
- Response mux:
  - dvalid=0: HREADY_M0=1, HRESP=OKAY, HRDATA=0.
  - dvalid=1 and ddef=0: outputs follow slave didx (HREADYOUT_S, HRESP_S, HRDATA_S).
  - dvalid=1 and ddef=1: the default slave runs.
- Default-slave FSM has states IDLE, ERR1, ERR2.
  - In ERR1 it drives HREADY_M0=0, HRESP=01. In ERR2 it drives HREADY_M0=1, HRESP=01.
  - It enters ERR1 on the cycle the unmapped data phase begins, then ERR2, then returns to IDLE.
  - HRDATA is 0 in all three states.
- IDLE and BUSY transfers to unmapped space never start the FSM.
- Slave ERROR responses pass straight through, unmodified.
- All outputs are held while HREADY_M0=0. Pipelining follows standard AHB: the next address phase overlaps the current data phase.

## Timing
- Decoder adds zero wait states. HSEL_S, the broadcast signals and the response mux are all combinational.
- Reset values (asynchronous): dvalid=0, FSM=IDLE, watchdog counter=0, HREADY_M0=1, HRESP_M0=00, HRDATA_M0=0, TIMEOUT_ERR=0.
- Reset asserted mid-transfer aborts the transfer immediately. No response is generated for it afterwards.
- An unmapped transfer during ERR2 (HREADY_M0=1) is accepted and starts a fresh ERR1 on the next cycle, so back-to-back errors are allowed.
- NUM_SLAVES=1: every idx other than 0 is routed to the default slave.

## Configuration
- Macro: AHB_DEC_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle where dvalid=1, ddef=0 and HREADYOUT_S[didx]=0. It clears on any cycle where HREADY_M0=1.
  - When the counter reaches TIMEOUT_CYCLES, the decoder takes over the response: ERR1 then ERR2 to the master, and a TIMEOUT_ERR pulse in the ERR1 cycle.
  - The stuck slave's HREADYOUT, HRESP and HRDATA are ignored from that point on.
- Not defined: no counter is built, TIMEOUT_ERR is tied to 0, and a hung slave stalls the bus indefinitely.

## Test plan
- NUM_SLAVES=4: write to 0x1000_0004, then read 0x0000_0000 with slave 0 returning 0xDEADBEEF -> HSEL_S=0010 and then 0001; HRDATA_M0=0xDEADBEEF with no extra wait states.
- NONSEQ read to 0x7000_0000 -> HREADY_M0=0 with HRESP=01, then HREADY_M0=1 with HRESP=01, then IDLE gives OKAY.
- Back-to-back unmapped, mapped, unmapped transfers -> ERR1 and ERR2 for each unmapped access; the mapped access completes normally in between.
- Slave 2 holds HREADYOUT low for 3 cycles, then returns ERROR -> master sees 3 wait cycles, and the slave's HRESP is passed through.
- With AHB_DEC_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave 1 never becomes ready -> after 8 stalled cycles, TIMEOUT_ERR pulses and the master sees a two-cycle ERROR; the next transfer to slave 0 succeeds.
- Assert HRESETN during ERR1 -> all outputs return to their reset values asynchronously; after release, the first IDLE gives HREADY_M0=1 and OKAY.

Source files
------------

// File: rtl/ahb_lite_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_lite_decoder_if                                             |
// | Purpose  : Bundles the single-master AHB-Lite request/response signals and |
// |            the fanned-out slave-side signals of ahb_lite_decoder.          |
// | Modports : slave  - decoder view (master request in, muxed response out,   |
// |                     slave selects/broadcast out, slave responses in)       |
// |            master - environment view (mirror of the slave modport)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ahb_lite_decoder_if #(
  parameter int NUM_SLAVES = 4
);
  // Master side
  logic [31:0]              HADDR_M0;
  logic [1:0]               HTRANS_M0;
  logic                     HWRITE_M0;
  logic [2:0]               HSIZE_M0;
  logic [2:0]               HBURST_M0;
  logic [3:0]               HPROT_M0;
  logic                     HMASTLOCK_M0;
  logic [31:0]              HWDATA_M0;
  logic                     HREADY_M0;
  logic [1:0]               HRESP_M0;
  logic [31:0]              HRDATA_M0;
  // Slave side
  logic [NUM_SLAVES-1:0]    HSEL_S;
  logic [31:0]              HADDR_S;
  logic [1:0]               HTRANS_S;
  logic                     HWRITE_S;
  logic [2:0]               HSIZE_S;
  logic [2:0]               HBURST_S;
  logic [3:0]               HPROT_S;
  logic                     HMASTLOCK_S;
  logic [31:0]              HWDATA_S;
  logic                     HREADY_S;
  logic [NUM_SLAVES-1:0]    HREADYOUT_S;
  logic [NUM_SLAVES-1:0]    HRESP_S;
  logic [32*NUM_SLAVES-1:0] HRDATA_S;
  // Watchdog
  logic                     TIMEOUT_ERR;

  modport slave (
    input  HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0,
           HMASTLOCK_M0, HWDATA_M0,
    output HREADY_M0, HRESP_M0, HRDATA_M0,
    output HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S,
           HMASTLOCK_S, HWDATA_S, HREADY_S,
    input  HREADYOUT_S, HRESP_S, HRDATA_S,
    output TIMEOUT_ERR
  );

  modport master (
    output HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0,
           HMASTLOCK_M0, HWDATA_M0,
    input  HREADY_M0, HRESP_M0, HRDATA_M0,
    input  HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S,
           HMASTLOCK_S, HWDATA_S, HREADY_S,
    output HREADYOUT_S, HRESP_S, HRDATA_S,
    input  TIMEOUT_ERR
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_lite_decoder                                                |
// | Purpose  : Single-master AHB-Lite address decoder and response mux with a |
// |            built-in default slave (two-cycle ERROR for unmapped space).    |
// | Ports    : HCLK    - bus clock                                             |
// |            HRESETN - asynchronous active-low reset                         |
// |            bus     - ahb_lite_decoder_if.slave (master request/response,  |
// |                      slave selects, broadcast, slave responses, watchdog)  |
// | Options  : `define AHB_DEC_TIMEOUT_EN builds a watchdog that aborts a     |
// |            data phase stalled for TIMEOUT_CYCLES cycles with an ERROR.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ahb_lite_decoder #(
  parameter int NUM_SLAVES     = 4,
  parameter int DEC_LSB        = 28,
  parameter int DEC_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire               HCLK,
  input  wire               HRESETN,
  ahb_lite_decoder_if.slave bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_err1 = 2'd1;
  localparam logic [1:0] c_err2 = 2'd2;

  // Elaboration-time parameter range checks
  if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
    $error("ahb_lite_decoder: NUM_SLAVES must be 1..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ahb_lite_decoder: TIMEOUT_CYCLES must be 2..65535");
  end

  logic [DEC_W-1:0]      w_idx;
  logic                  w_unmapped;
  logic [NUM_SLAVES-1:0] w_hsel;
  logic                  w_hready;
  logic                  w_err;
  logic [31:0]           w_rdata;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [31:0]           w_sel_rdata;
  logic                  w_timeout;

  logic [1:0]            state_q, state_d;
  logic                  dvalid_q, dvalid_d;
  logic                  ddef_q, ddef_d;
  logic [DEC_W-1:0]      didx_q, didx_d;

  // ---------------- Address phase (combinational) ----------------
  assign w_idx      = bus.HADDR_M0[DEC_LSB +: DEC_W];
  assign w_unmapped = (32'(w_idx) >= 32'(NUM_SLAVES));

  always_comb begin
    w_hsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hsel[i] = (32'(w_idx) == 32'(i));
    end
  end

  assign bus.HSEL_S      = w_hsel;
  assign bus.HADDR_S     = bus.HADDR_M0;
  assign bus.HTRANS_S    = bus.HTRANS_M0;
  assign bus.HWRITE_S    = bus.HWRITE_M0;
  assign bus.HSIZE_S     = bus.HSIZE_M0;
  assign bus.HBURST_S    = bus.HBURST_M0;
  assign bus.HPROT_S     = bus.HPROT_M0;
  assign bus.HMASTLOCK_S = bus.HMASTLOCK_M0;
  assign bus.HWDATA_S    = bus.HWDATA_M0;
  assign bus.HREADY_S    = w_hready;
  assign bus.HREADY_M0   = w_hready;
  assign bus.HRESP_M0    = {1'b0, w_err};
  assign bus.HRDATA_M0   = w_rdata;

  // ---------------- Data-phase register ----------------
  // Only advances when the bus is ready, so every response is held across
  // wait states.
  always_comb begin
    dvalid_d = dvalid_q;
    ddef_d   = ddef_q;
    didx_d   = didx_q;
    if (w_hready) begin
      dvalid_d = bus.HTRANS_M0[1];
      ddef_d   = w_unmapped;
      didx_d   = w_idx;
    end
  end

  // Selected slave's response for the current data phase
  always_comb begin
    w_sel_ready = 1'b1;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(didx_q) == 32'(i)) begin
        w_sel_ready = bus.HREADYOUT_S[i];
        w_sel_err   = bus.HRESP_S[i];
        w_sel_rdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

  // ---------------- Response mux ----------------
  // The default-slave FSM has priority so a watchdog abort overrides the
  // stuck slave.
  always_comb begin
    w_hready = 1'b1;
    w_err    = 1'b0;
    w_rdata  = '0;
    case (state_q)
      c_err1: begin
        w_hready = 1'b0;
        w_err    = 1'b1;
      end
      c_err2: w_err = 1'b1;
      default: begin
        if (dvalid_q && !ddef_q) begin
          w_hready = w_sel_ready;
          w_err    = w_sel_err;
          w_rdata  = w_sel_rdata;
        end
      end
    endcase
  end

  // ---------------- Default-slave FSM ----------------
  // An accepted NONSEQ/SEQ to unmapped space (including one accepted during
  // ERR2) starts ERR1 on the next cycle; IDLE/BUSY never do.
  always_comb begin
    state_d = state_q;
    if (w_hready) begin
      state_d = (bus.HTRANS_M0[1] && w_unmapped) ? c_err1 : c_idle;
    end else if (state_q == c_err1) begin
      state_d = c_err2;
    end else if (w_timeout) begin
      state_d = c_err1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= c_idle;
      dvalid_q <= 1'b0;
      ddef_q   <= 1'b0;
      didx_q   <= '0;
    end else begin
      state_q  <= state_d;
      dvalid_q <= dvalid_d;
      ddef_q   <= ddef_d;
      didx_q   <= didx_d;
    end
  end

  // ---------------- Optional watchdog ----------------
`ifdef AHB_DEC_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        to_q;
  logic        w_stall;

  // Stalled cycle of a mapped data phase not yet taken over by the FSM
  assign w_stall = (state_q == c_idle) && dvalid_q && !ddef_q && !w_sel_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (w_hready) begin
      cnt_d = '0;
    end else if (w_stall) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Fires on the stalled cycle that brings the count to the limit; the FSM
  // is in ERR1 on the following cycle, which is when the pulse is visible.
  assign w_timeout = w_stall && (cnt_d == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= w_timeout;
    end
  end

  assign bus.TIMEOUT_ERR = to_q;
`else
  assign w_timeout       = 1'b0;
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
